// File: rtl/dsp_shift_pkg.sv
// Shared definitions for the tap-line blocks: FSM state encoding and a
// slice-extraction helper for packed multi-tap words.
package dsp_shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Widest packed word the helper handles; callers zero-extend into it.
  localparam int unsigned SLICE_WORD_MAX = 1024;

  function automatic logic [SLICE_WORD_MAX-1:0] tap_slice(
    input logic [SLICE_WORD_MAX-1:0] word,
    input int unsigned               idx,
    input int unsigned               w
  );
    return word >> (idx * w);
  endfunction

endpackage

// File: rtl/taps_serializer_hold.sv
// Second taps holding register with full flag; lets the next word wait while
// the current one is still being serialized.
module taps_serializer_hold #(
  parameter int RAM_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clken_i,
  input  logic                 sclr_i,
  input  logic                 load_i,
  input  logic                 drain_i,
  input  logic [RAM_WIDTH-1:0] word_i,
  output logic [RAM_WIDTH-1:0] word_o,
  output logic                 full_o
);

  logic [RAM_WIDTH-1:0] word_q, word_d;
  logic                 full_q, full_d;

  // A load in the same cycle as a drain replaces the departing word.
  always_comb begin
    word_d = word_q;
    full_d = full_q;
    if (load_i) begin
      word_d = word_i;
      full_d = 1'b1;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else if (clken_i) begin
      if (sclr_i) begin
        word_q <= '0;
        full_q <= 1'b0;
      end else begin
        word_q <= word_d;
        full_q <= full_d;
      end
    end
  end

  assign word_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/taps_serializer.sv
// Parallel-in / serial-out taps serializer: replays a packed taps word oldest
// slice first. Define TAPS_SERIALIZER_DBUF_EN for the double-buffered variant.
module taps_serializer
  import dsp_shift_pkg::*;
#(
  parameter int number_of_taps = 4,
  parameter int tap_distance   = 3,
  parameter int width          = 8,
  parameter int RAM_WIDTH      = width * number_of_taps
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 clken,
  input  logic                 sclr,
  input  logic [RAM_WIDTH-1:0] taps,
  input  logic                 taps_valid,
  output logic                 taps_ready,
  output logic [width-1:0]     shiftout,
  output logic                 shiftout_valid,
  input  logic                 shiftout_ready,
  output logic                 shiftout_last
);

  localparam int CW = $clog2(number_of_taps);
  localparam int GW = $clog2(tap_distance) + 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(number_of_taps - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(tap_distance - 1);

  function automatic logic [width-1:0] slice_of(input logic [RAM_WIDTH-1:0] w,
                                                input logic [CW-1:0] i);
    return width'(tap_slice(SLICE_WORD_MAX'(w), 32'(i), 32'(width)));
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [RAM_WIDTH-1:0] word_q, word_d;
  logic [width-1:0]     out_q, out_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;

  logic                 en_fire, taps_fire, beat_fire, refill, adv;
  logic [RAM_WIDTH-1:0] refill_word, adv_word;
  logic [CW-1:0]        adv_idx;
  logic                 hold_full;
  logic [RAM_WIDTH-1:0] hold_word;

  assign en_fire   = clken && !sclr;
  assign taps_fire = en_fire && taps_valid && taps_ready;
  assign beat_fire = en_fire && vld_q && shiftout_ready;

`ifdef TAPS_SERIALIZER_DBUF_EN
  logic done, hold_load, hold_drain;

  assign done       = beat_fire && (state_q == ST_SHIFT) && (cnt_q == '0);
  assign taps_ready = !hold_full;
  assign hold_drain = done && hold_full;
  // A word arriving just as the current one finishes with an empty holder
  // bypasses the holder and goes straight into the shift register.
  assign hold_load  = taps_fire && (state_q != ST_IDLE) && !(done && !hold_full);

  taps_serializer_hold #(.RAM_WIDTH(RAM_WIDTH)) u_hold (
    .clk_i   (clock),
    .rst_n_i (aclr_n),
    .clken_i (clken),
    .sclr_i  (sclr),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .word_i  (taps),
    .word_o  (hold_word),
    .full_o  (hold_full)
  );
`else
  assign taps_ready = (state_q == ST_IDLE);
  assign hold_full  = 1'b0;
  assign hold_word  = '0;
`endif

  assign refill      = hold_full || (taps_fire && (state_q != ST_IDLE));
  assign refill_word = hold_full ? hold_word : taps;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    word_d   = word_q;
    out_d    = out_q;
    vld_d    = vld_q;
    last_d   = last_q;
    adv      = 1'b0;
    adv_word = word_q;
    adv_idx  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (taps_fire) begin
          word_d  = taps;
          cnt_d   = CNT_TOP;
          out_d   = slice_of(taps, CNT_TOP);
          vld_d   = 1'b1;
          last_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat_fire) begin
          if (cnt_q != '0) begin
            adv     = 1'b1;
            adv_idx = cnt_q - 1'b1;
          end else if (refill) begin
            adv      = 1'b1;
            adv_word = refill_word;
            adv_idx  = CNT_TOP;
            word_d   = refill_word;
          end else begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end
          cnt_d = adv_idx;
        end
      end
      ST_GAP: begin
        if (en_fire) begin
          if (gap_q <= GW'(1)) begin
            state_d = ST_SHIFT;
            out_d   = slice_of(word_q, cnt_q);
            vld_d   = 1'b1;
            last_d  = (cnt_q == '0);
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Next slice either follows immediately or after the inter-beat gap.
    if (adv) begin
      if (tap_distance > 1) begin
        state_d = ST_GAP;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        gap_d   = GAP_TOP;
      end else begin
        state_d = ST_SHIFT;
        out_d   = slice_of(adv_word, adv_idx);
        vld_d   = 1'b1;
        last_d  = (adv_idx == '0);
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (clken) begin
      if (sclr) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        gap_q   <= '0;
        word_q  <= '0;
        out_q   <= '0;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        gap_q   <= gap_d;
        word_q  <= word_d;
        out_q   <= out_d;
        vld_q   <= vld_d;
        last_q  <= last_d;
      end
    end
  end

  assign shiftout       = out_q;
  assign shiftout_valid = vld_q;
  assign shiftout_last  = last_q;

endmodule
